// File: rtl/cla_decrypt.sv
// Bit-serial recovery of a = (s - b - c) ^ k, one bit per clock through a single borrow flop.
// Flags err when the difference leaves [0, 2^WIDTH-1].
module cla_decrypt #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   s,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic [WIDTH-1:0] k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic             err
);

  localparam int IDX_W = (WIDTH < 1) ? 1 : $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH:0]     s_reg;
  logic [WIDTH:0]     b_reg;
  logic [WIDTH-1:0]   k_reg;
  logic [WIDTH:0]     diff;
  logic [IDX_W-1:0]   idx;
  logic               borrow;

  logic               accept;
  logic               last_bit;
  logic               s_bit;
  logic               b_bit;
  logic               d_bit;
  logic               borrow_nxt;

  assign accept     = in_valid & in_ready;
  assign last_bit   = (state == SUB) && (idx == IDX_W'(WIDTH));
  assign s_bit      = s_reg[idx];
  assign b_bit      = b_reg[idx];
  assign d_bit      = s_bit ^ b_bit ^ borrow;
  assign borrow_nxt = (~s_bit & b_bit) | (~(s_bit ^ b_bit) & borrow);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)                state_nxt = SUB;
      SUB:     if (last_bit)              state_nxt = DONE;
      DONE:    if (out_valid & out_ready) state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Accept captures operands; each SUB cycle ripples one difference bit, the last one registers the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg  <= '0;
      b_reg  <= '0;
      k_reg  <= '0;
      diff   <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      a      <= '0;
      err    <= 1'b0;
    end else if (accept) begin
      s_reg  <= s;
      b_reg  <= {1'b0, b};
      k_reg  <= k;
      diff   <= '0;
      idx    <= '0;
      borrow <= c;
    end else if (state == SUB) begin
      diff[idx] <= d_bit;
      borrow    <= borrow_nxt;
      idx       <= idx + IDX_W'(1);
      if (last_bit) begin
        // Bits below WIDTH are already in diff; the top bit is the one produced this cycle.
        a   <= diff[WIDTH-1:0] ^ k_reg;
        err <= borrow_nxt | d_bit;
      end
    end
  end

endmodule

// File: tb/tb_cla_decrypt.sv
// Directed bench for cla_decrypt at WIDTH=2 with hand-computed results.
module tb_cla_decrypt;

  localparam int WIDTH = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH:0]   s = '0;
  logic [WIDTH-1:0] b = '0;
  logic             c = 1'b0;
  logic [WIDTH-1:0] k = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] a;
  logic             err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_decrypt #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .b         (b),
    .c         (c),
    .k         (k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .err       (err)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (a !== 2'd0) begin errors++; $display("FAIL reset_a got %0d want 0", a); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Offer one transaction at a negedge, check latency, result, then complete the handshake.
  task automatic run_txn(input string name, input logic [2:0] ts, input logic [1:0] tb_,
                         input logic tc, input logic [1:0] tk,
                         input logic [1:0] exp_a, input logic exp_err);
    s = ts; b = tb_; c = tc; k = tk; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_busy in_ready got %b want 0", name, in_ready); end
    for (int n = 1; n <= 3; n++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== (n == 3)) begin
        errors++; $display("FAIL %s_latency cycle %0d out_valid got %b want %b", name, n, out_valid, (n == 3));
      end
    end
    checks++; if (a !== exp_a) begin errors++; $display("FAIL %s_a got %0d want %0d", name, a, exp_a); end
    checks++; if (err !== exp_err) begin errors++; $display("FAIL %s_err got %b want %b", name, err, exp_err); end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_release out_valid got %b want 0", name, out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_release in_ready got %b want 1", name, in_ready); end
    @(negedge clk);
  endtask

  task automatic test_nominal();
    run_txn("nominal", 3'd5, 2'd2, 1'b1, 2'd2, 2'd0, 1'b0);
  endtask

  task automatic test_max_operand();
    run_txn("max", 3'd7, 2'd3, 1'b1, 2'd1, 2'd2, 1'b0);
  endtask

  task automatic test_underflow();
    run_txn("underflow", 3'd0, 2'd1, 1'b0, 2'd0, 2'd3, 1'b1);
  endtask

  task automatic test_overflow();
    run_txn("overflow", 3'd7, 2'd0, 1'b0, 2'd0, 2'd3, 1'b1);
  endtask

  task automatic test_backpressure();
    // 6 - 1 - 0 = 5 -> out of range, low bits 01 ^ 10 = 11
    s = 3'd6; b = 2'd1; c = 1'b0; k = 2'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int n = 0; n < 5; n++) begin
      if (n == 2) begin
        s = 3'd1; b = 2'd0; c = 1'b0; k = 2'd0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cycle %0d got %b want 1", n, out_valid); end
      checks++; if (a !== 2'd3) begin errors++; $display("FAIL bp_a cycle %0d got %0d want 3", n, a); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL bp_err cycle %0d got %b want 1", n, err); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b want 0", n, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_ignored cycle %0d out_valid got %b want 0", n, out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle cycle %0d in_ready got %b want 1", n, in_ready); end
      @(posedge clk); #1;
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    s = 3'd7; b = 2'd3; c = 1'b1; k = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept1 in_ready got %b want 0", in_ready); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out1 out_valid got %b want 1", out_valid); end
    checks++; if (a !== 2'd2) begin errors++; $display("FAIL b2b_a1 got %0d want 2", a); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse1 out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_noaccept in_ready got %b want 1", in_ready); end
    s = 3'd5; b = 2'd2; c = 1'b1; k = 2'd2;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept2 in_ready got %b want 0", in_ready); end
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out2 out_valid got %b want 1", out_valid); end
    checks++; if (a !== 2'd0) begin errors++; $display("FAIL b2b_a2 got %0d want 0", a); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse2 out_valid got %b want 0", out_valid); end
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_sub();
    // Registered result still holds 3/1 from the previous underflow-style transaction.
    run_txn("pre_reset", 3'd0, 2'd1, 1'b0, 2'd0, 2'd3, 1'b1);
    s = 3'd7; b = 2'd0; c = 1'b0; k = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    checks++; if (a !== 2'd0) begin errors++; $display("FAIL midrst_a got %0d want 0", a); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err got %b want 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_output cycle %0d out_valid got %b want 0", n, out_valid); end
    end
    @(negedge clk);
    run_txn("post_reset", 3'd5, 2'd2, 1'b1, 2'd2, 2'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_max_operand();
    test_underflow();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_sub();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
